data_ram: RTL
=============

DATA_RAM -- requirements
Module: data_ram

Interface
- REQ-001: Parameter DEPTH_WORDS, default 1024, sets the number of 32-bit storage words; power of two, 16..65536.
- REQ-002: clk  input  1  sole clock; all state updates on its rising edge.
- REQ-003: rst  input  1  reset, asynchronous, active-high.
- REQ-004: ce_i  input  1  chip enable from the core data port; 1 = access this cycle.
- REQ-005: we_i  input  1  write enable; 1 = write, 0 = read (qualified by ce_i).
- REQ-006: sel_i  input  4  byte-lane enables; sel_i[3] maps to data[31:24] (lowest byte address, big-endian), sel_i[0] maps to data[7:0].
- REQ-007: addr_i  input  32  byte address; word index = addr_i[AW+1:2], where AW = log2(DEPTH_WORDS).
- REQ-008: data_i  input  32  write data from the core.
- REQ-009: data_o  output  32  read data returned to the core.
- REQ-010: err_clr_i  input  1  synchronous clear of the error capture.
- REQ-011: err_o  output  1  sticky out-of-range access flag.
- REQ-012: err_addr_o  output  32  address of the first out-of-range access since the last clear.
- REQ-013: cnt_clr_i  input  1  synchronous clear of the access counters.
- REQ-014: rd_cnt_o  output  32  accepted read count.
- REQ-015: wr_cnt_o  output  32  accepted write count.

Function
- REQ-016: An access is in range when addr_i[31:AW+2] == 0; addr_i[1:0] SHALL be ignored.
- REQ-017: Write: when ce_i=1, we_i=1 and the address is in range, each lane with sel_i[n]=1 SHALL update at the rising edge of clk; lanes with sel_i[n]=0 SHALL keep their contents.
- REQ-018: Read: data_o SHALL be combinational, with zero-cycle latency, equal to the full addressed word when ce_i=1, we_i=0 and the address is in range; sel_i SHALL NOT mask read data.
- REQ-019: data_o SHALL be 32'h0 when ce_i=0, when we_i=1, or when the address is out of range.
- REQ-020: Read and write in the same cycle to the same word: the read SHALL see the pre-edge contents; the new data is visible from the next cycle.
- REQ-021: An out-of-range access with ce_i=1 SHALL NOT modify storage.
- REQ-022: Error capture is two states, CLEAN and LATCHED.
  - CLEAN -> LATCHED on an out-of-range access with ce_i=1; err_addr_o loads addr_i in the same edge.
  - LATCHED -> CLEAN on err_clr_i=1.
  - In LATCHED, further errors SHALL NOT update err_addr_o.
  - err_o=1 in LATCHED.
- REQ-023: If err_clr_i=1 and an out-of-range access occur in the same cycle, the result SHALL be LATCHED with err_addr_o = the new address (clear first, then capture).
- REQ-024: The handshake is single-cycle: no stall or ready signal; every ce_i=1 cycle is an independent access.

Reset
- REQ-025: While rst=1, err_o=0, err_addr_o=0, rd_cnt_o=0 and wr_cnt_o=0 asynchronously; the error capture SHALL be in CLEAN.
- REQ-026: Storage contents SHALL NOT be reset.
- REQ-027: A write coincident with reset assertion SHALL be discarded.
- REQ-028: data_o remains combinational during reset and follows REQ-018 and REQ-019.

Configuration
- REQ-029: Macro DATA_RAM_STATS_EN defined: rd_cnt_o / wr_cnt_o SHALL increment by 1 per in-range read / write cycle with ce_i=1.
  - Counters saturate at 32'hFFFFFFFF.
  - cnt_clr_i=1 forces 0 and wins over a same-cycle increment.
- REQ-030: Macro DATA_RAM_STATS_EN undefined: no counter registers SHALL exist; rd_cnt_o and wr_cnt_o SHALL be constant 0 and cnt_clr_i SHALL be ignored.

Verification
- REQ-031: Write 32'hDEADBEEF, sel=4'hF, addr=32'h0000_0010; then read addr 32'h10 -> data_o=32'hDEADBEEF; read addr 32'h13 -> 32'hDEADBEEF.
- REQ-032: Over 32'hDEADBEEF, write 32'h11223344 with sel=4'b0100 at addr 32'h10; read -> 32'hDE22BEEF.
- REQ-033: Same-cycle read and write to addr 32'h20 (old 32'h0, write 32'h55): that cycle's sampled data_o=32'h0; next cycle's read -> 32'h55.
- REQ-034: DEPTH_WORDS=1024:
  - Write to 32'h0000_1000 -> storage unchanged, err_o=1, err_addr_o=32'h1000.
  - Then a read of 32'h0000_2000 -> data_o=0, err_addr_o stays 32'h1000.
  - Then err_clr_i plus an access to 32'h3000 in the same cycle -> err_addr_o=32'h3000.
- REQ-035: STATS_EN defined:
  - 3 in-range reads, 2 writes and 1 out-of-range read -> rd_cnt_o=3, wr_cnt_o=2.
  - cnt_clr_i with a concurrent read -> both counters 0.
  - Force rd_cnt_o to 32'hFFFFFFFF, then read -> stays 32'hFFFFFFFF.
- REQ-036: Assert rst mid-write (ce_i=1, we_i=1) -> outputs 0 immediately, target word unchanged; after release, err_o=0.

Source files
------------

// File: rtl/data_ram.sv
// Single-port byte-lane data RAM with combinational read and sticky range-error capture.
// Define DATA_RAM_STATS_EN to build the saturating read/write access counters.
module data_ram #(
   parameter int DEPTH_WORDS = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ce_i,
   input  logic        we_i,
   input  logic [3:0]  sel_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] data_i,
   output logic [31:0] data_o,
   input  logic        err_clr_i,
   output logic        err_o,
   output logic [31:0] err_addr_o,
   input  logic        cnt_clr_i,
   output logic [31:0] rd_cnt_o,
   output logic [31:0] wr_cnt_o
);

   localparam int AW = $clog2(DEPTH_WORDS);

   typedef enum logic {
      CLEAN,
      LATCHED
   } err_st_t;

   logic [31:0]   mem [DEPTH_WORDS];
   logic [AW-1:0] idx;
   logic          in_rng;
   logic          rd_en;
   logic          wr_en;
   logic          oor;
   err_st_t       err_st;

   assign in_rng = (addr_i >> (AW + 2)) == 32'h0;
   assign idx    = addr_i[AW+1:2];
   assign rd_en  = ce_i & ~we_i & in_rng;
   assign wr_en  = ce_i & we_i & in_rng;
   assign oor    = ce_i & ~in_rng;

   // Read returns pre-edge contents; sel_i only masks writes.
   assign data_o = rd_en ? mem[idx] : 32'h0;

   // Storage has no reset; a write sampled while rst is high is dropped.
   always_ff @(posedge clk) begin
      if (wr_en && !rst) begin
         for (int n = 0; n < 4; n++) begin
            if (sel_i[n]) begin
               mem[idx][8*n +: 8] <= data_i[8*n +: 8];
            end
         end
      end
   end

   // Clear takes effect before capture, so clear+error re-latches.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_st     <= CLEAN;
         err_o      <= 1'b0;
         err_addr_o <= 32'h0;
      end else begin
         if (oor && (err_st == CLEAN || err_clr_i)) begin
            err_st     <= LATCHED;
            err_o      <= 1'b1;
            err_addr_o <= addr_i;
         end else if (err_clr_i) begin
            err_st <= CLEAN;
            err_o  <= 1'b0;
         end
      end
   end

`ifdef DATA_RAM_STATS_EN
   logic [31:0] rd_cnt_q;
   logic [31:0] wr_cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_cnt_q <= 32'h0;
         wr_cnt_q <= 32'h0;
      end else if (cnt_clr_i) begin
         rd_cnt_q <= 32'h0;
         wr_cnt_q <= 32'h0;
      end else begin
         if (rd_en && rd_cnt_q != 32'hFFFF_FFFF) begin
            rd_cnt_q <= rd_cnt_q + 32'h1;
         end
         if (wr_en && wr_cnt_q != 32'hFFFF_FFFF) begin
            wr_cnt_q <= wr_cnt_q + 32'h1;
         end
      end
   end

   assign rd_cnt_o = rd_cnt_q;
   assign wr_cnt_o = wr_cnt_q;
`else
   logic unused_cnt_clr;

   assign unused_cnt_clr = cnt_clr_i;
   assign rd_cnt_o       = 32'h0;
   assign wr_cnt_o       = 32'h0;
`endif

endmodule
